// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: one data-memory request per
// load/store, load alignment/extension, store strobes, and the MEM/WB register.
package core;
    typedef struct packed {
        logic        valid;
        logic [31:0] de_inst;
        logic [31:0] ex_result;
        logic [31:0] rs2_value;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] de_inst;
        logic [31:0] ex_result;
        logic [31:0] mem_result;
    } mem_wb_t;
endpackage

module mem_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  core::ex_mem_t   ex_mem,
    output core::mem_wb_t   mem_wb,
    output logic            rdy,
    output logic            misalign,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HELD = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic            is_load;
    logic            is_store;
    logic            bad_align;
    logic            mem_op;
    logic            bad_access;
    logic            pass;
    logic            complete;
    logic [XLEN-1:0] held_rdata;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_result;

    assign opcode     = ex_mem.de_inst[6:0];
    assign funct3     = ex_mem.de_inst[14:12];
    assign off        = ex_mem.ex_result[1:0];
    assign is_load    = ex_mem.valid && (opcode == OP_LOAD);
    assign is_store   = ex_mem.valid && (opcode == OP_STORE);
    assign bad_align  = ((funct3[1:0] == 2'b01) && off[0]) ||
                        ((funct3[1:0] == 2'b10) && (off != 2'b00));
    assign mem_op     = (is_load || is_store) && !bad_align;
    assign bad_access = (is_load || is_store) && bad_align;

    assign pass     = en && (state == S_IDLE) && !mem_op;
    assign complete = en && (((state == S_WAIT) && dmem_rsp_valid) || (state == S_HELD));
    assign rdy      = pass || complete;

    // A request presented from REQ stays up regardless of en; upstream is stalled so ex_mem is stable.
    assign dmem_req_valid = ((state == S_IDLE) && mem_op && en) || (state == S_REQ);
    assign dmem_req_we    = is_store;
    assign dmem_req_addr  = {ex_mem.ex_result[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_req_wdata = ex_mem.rs2_value;
        dmem_req_wstrb = '0;
        case (funct3)
            3'b000: begin
                dmem_req_wdata = {4{ex_mem.rs2_value[7:0]}};
                dmem_req_wstrb = 4'b0001 << off;
            end
            3'b001: begin
                dmem_req_wdata = {2{ex_mem.rs2_value[15:0]}};
                dmem_req_wstrb = 4'b0011 << off;
            end
            3'b010: dmem_req_wstrb = 4'b1111;
            default: dmem_req_wstrb = '0;
        endcase
        if (!is_store) begin
            dmem_req_wstrb = '0;
        end
    end

    assign load_word = (state == S_HELD) ? held_rdata : dmem_rsp_rdata;
    assign lane      = load_word >> {off, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  load_result = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  load_result = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  load_result = load_word;
            3'b100:  load_result = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  load_result = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_result = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mem_op && en) state_nxt = dmem_req_ready ? S_WAIT : S_REQ;
            S_REQ:  if (dmem_req_ready) state_nxt = S_WAIT;
            S_WAIT: if (dmem_rsp_valid) state_nxt = en ? S_IDLE : S_HELD;
            S_HELD: if (en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mem_wb     <= '0;
            misalign   <= 1'b0;
            held_rdata <= '0;
        end else begin
            state    <= state_nxt;
            misalign <= pass && bad_access;
            if ((state == S_WAIT) && dmem_rsp_valid && !en) begin
                held_rdata <= dmem_rsp_rdata;
            end
            if (complete) begin
                mem_wb <= '{valid: 1'b1, de_inst: ex_mem.de_inst, ex_result: ex_mem.ex_result,
                            mem_result: is_load ? load_result : '0};
            end else if (pass) begin
                mem_wb <= '{valid: ex_mem.valid, de_inst: ex_mem.de_inst,
                            ex_result: ex_mem.ex_result, mem_result: '0};
            end else if (en) begin
                mem_wb.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed memory model, request/writeback scoreboards,
// directed corner cases followed by randomized traffic.
module tb_mem_stage;
    import core::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;
    logic        rdy;
    logic        misalign;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .en(en), .ex_mem(ex_mem), .mem_wb(mem_wb),
        .rdy(rdy), .misalign(misalign),
        .dmem_req_valid(req_valid), .dmem_req_ready(req_ready), .dmem_req_we(req_we),
        .dmem_req_addr(req_addr), .dmem_req_wdata(req_wdata), .dmem_req_wstrb(req_wstrb),
        .dmem_rsp_valid(rsp_valid), .dmem_rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] result;
        logic        misal;
    } wb_t;

    logic [7:0] mem_b [64];
    req_t       req_q [$];
    wb_t        wb_q  [$];
    req_t       last_req;

    int n_checks = 0;
    int n_fail   = 0;

    int ready_wait    = 0;
    int rsp_delay     = 0;
    int en_pct        = 100;
    bit en_low_on_rsp = 1'b0;
    bit stray_rsp     = 1'b0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, required none", name);
    endfunction

    // Memory responder: one response per accepted request, plus request-stability checks.
    initial begin
        bit          pending;
        int          cnt;
        int          wait_cnt;
        bit          stall_prev;
        logic [31:0] pend_word;
        req_t        s;
        req_t        e;
        pending = 0; cnt = 0; wait_cnt = 0; stall_prev = 0; pend_word = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (stray_rsp) begin
                rsp_valid = 1'b1;
                rsp_rdata = $urandom;
                stray_rsp = 1'b0;
            end else if (pending) begin
                if (cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = pend_word;
                    pending   = 0;
                end else begin
                    cnt--;
                end
            end
            req_ready = (ready_wait >= 0) ? (wait_cnt >= ready_wait) : ($urandom_range(0, 99) < 60);
            #2;
            if (!rst) begin
                pending = 0; wait_cnt = 0; stall_prev = 0;
                continue;
            end
            if (stall_prev) begin
                check("req_hold_valid", req_valid, 1'b1);
                check("req_hold_addr", req_addr, s.addr);
                check("req_hold_we", req_we, s.we);
                check("req_hold_wstrb", req_wstrb, s.wstrb);
                check("req_hold_wdata", req_wdata, s.wdata);
            end
            s = '{req_addr, req_we, req_wstrb, req_wdata};
            if (req_valid && req_ready) begin
                last_req = s;
                if (req_q.size() == 0) begin
                    fail_event("req_unexpected");
                end else begin
                    e = req_q.pop_front();
                    check("req_addr", req_addr, e.addr);
                    check("req_we", req_we, e.we);
                    check("req_wstrb", req_wstrb, e.wstrb);
                    if (e.we) check("req_wdata", req_wdata, e.wdata);
                    for (int i = 0; i < 4; i++) begin
                        pend_word[8*i +: 8] = mem_b[{e.addr[5:2], 2'(i)}];
                        if (e.we && e.wstrb[i]) mem_b[{e.addr[5:2], 2'(i)}] = e.wdata[8*i +: 8];
                    end
                end
                pending    = 1;
                cnt        = (rsp_delay >= 0) ? rsp_delay : $urandom_range(0, 3);
                wait_cnt   = 0;
                stall_prev = 0;
            end else if (req_valid) begin
                wait_cnt++;
                stall_prev = 1;
            end else begin
                wait_cnt   = 0;
                stall_prev = 0;
            end
        end
    end

    // Writeback monitor: pops the scoreboard on each retirement, checks bubbles and holds otherwise.
    initial begin
        bit      prev_fire;
        bit      prev_en;
        mem_wb_t snap;
        wb_t     w;
        prev_fire = 0; prev_en = 1; snap = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                prev_fire = 0; prev_en = 1; snap = mem_wb;
                continue;
            end
            if (prev_fire && mem_wb.valid) begin
                if (wb_q.size() == 0) begin
                    fail_event("wb_unexpected");
                end else begin
                    w = wb_q.pop_front();
                    check("wb_inst", mem_wb.de_inst, w.inst);
                    check("wb_addr", mem_wb.ex_result, w.addr);
                    check("wb_result", mem_wb.mem_result, w.result);
                    check("wb_misalign", misalign, w.misal);
                end
            end else begin
                check("misalign_quiet", misalign, 1'b0);
                if (!prev_en) check("wb_hold", mem_wb, snap);
                else          check("wb_bubble", mem_wb.valid, 1'b0);
            end
            prev_fire = rdy && en;
            prev_en   = en;
            snap      = mem_wb;
        end
    end

    // Present one ex_mem entry (call at posedge+#1); returns cycles until it was consumed.
    task automatic issue(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] rs2, output int cycles);
        logic [6:0]  op;
        int          f3;
        int          size;
        bit          ld;
        bit          st;
        bit          misal;
        bit          fired;
        logic [31:0] res;
        req_t        r;
        wb_t         w;
        op    = inst[6:0];
        f3    = int'(inst[14:12]);
        ld    = v && (op == 7'h03);
        st    = v && (op == 7'h23);
        size  = 1 << (f3 % 4);
        misal = (ld || st) && ((addr % size) != 0);
        res   = '0;
        if (ld && !misal) begin
            for (int i = 0; i < size; i++) res = res | (32'(mem_b[addr[5:0] + 6'(i)]) << (8 * i));
            if (f3 < 4 && size < 4 && res[8*size-1]) res = res | ~((32'h1 << (8 * size)) - 1);
        end
        if ((ld || st) && !misal) begin
            r.addr  = addr & ~32'h3;
            r.we    = st;
            r.wstrb = st ? 4'(((1 << size) - 1) << (addr % 4)) : 4'h0;
            for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
            req_q.push_back(r);
        end
        if (v) begin
            w = '{inst, addr, res, misal};
            wb_q.push_back(w);
        end
        ex_mem = '{valid: v, de_inst: inst, ex_result: addr, rs2_value: rs2};
        cycles = 0;
        forever begin
            @(negedge clk);
            #1;
            if (en_low_on_rsp && rsp_valid) begin
                en = 1'b0;
                en_low_on_rsp = 1'b0;
            end else begin
                en = ($urandom_range(0, 99) < en_pct);
            end
            #1;
            fired = rdy && en;
            @(posedge clk);
            cycles++;
            if (fired) break;
            if (cycles >= 200) begin
                fail_event("issue_timeout");
                break;
            end
        end
        #1;
    endtask

    initial begin
        int          c;
        int          kind;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] rs2;
        int          f3;
        int          ld_f3 [5] = '{0, 1, 2, 4, 5};

        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
        rst = 1'b0; en = 1'b0; ex_mem = '0;
        repeat (3) @(negedge clk);
        check("reset_mem_wb", mem_wb, 97'b0);
        check("reset_misalign", misalign, 1'b0);
        check("reset_req_valid", req_valid, 1'b0);
        check("reset_rdy", rdy, 1'b0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // add x5 -> single-cycle passthrough
        issue(1'b1, 32'h000002B3, 32'h00001234, 32'h0, c);
        check("add_latency", c, 1);
        check("add_valid", mem_wb.valid, 1'b1);
        check("add_result", mem_wb.ex_result, 32'h00001234);

        // lb at byte offset 3 of word 0x80FFFFFF
        mem_b[16] = 8'hFF; mem_b[17] = 8'hFF; mem_b[18] = 8'hFF; mem_b[19] = 8'h80;
        issue(1'b1, 32'h00000283, 32'h00000013, 32'h0, c);
        check("lb_latency", c, 2);
        check("lb_result", mem_wb.mem_result, 32'hFFFFFF80);

        // sh to 0x102
        issue(1'b1, 32'h00001023, 32'h00000102, 32'hABCD1234, c);
        check("sh_latency", c, 2);
        check("sh_addr", last_req.addr, 32'h00000100);
        check("sh_wstrb", last_req.wstrb, 4'b1100);
        check("sh_wdata", last_req.wdata, 32'h12341234);
        check("sh_we", last_req.we, 1'b1);

        // misaligned lw: no request, one-cycle misalign pulse
        issue(1'b1, 32'h00002283, 32'h00000101, 32'h0, c);
        check("mis_latency", c, 1);
        check("mis_pulse", misalign, 1'b1);
        check("mis_valid", mem_wb.valid, 1'b1);
        check("mis_result", mem_wb.mem_result, 32'h0);
        issue(1'b0, 32'h0, 32'h0, 32'h0, c);
        check("mis_pulse_end", misalign, 1'b0);

        // lhu with ready low 3 cycles and en dropped on the response cycle
        mem_b[32] = 8'h0D; mem_b[33] = 8'hF0; mem_b[34] = 8'h00; mem_b[35] = 8'h00;
        ready_wait = 3; en_low_on_rsp = 1'b1;
        issue(1'b1, 32'h00005283, 32'h00000020, 32'h0, c);
        check("lhu_latency", c, 6);
        check("lhu_result", mem_wb.mem_result, 32'h0000F00D);
        ready_wait = 0;

        // reset while waiting for a response, then a stray response
        rsp_delay = 20;
        req_q.push_back('{32'h00000024, 1'b0, 4'h0, 32'h0});
        ex_mem = '{valid: 1'b1, de_inst: 32'h00002283, ex_result: 32'h00000024, rs2_value: 32'h0};
        @(negedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wait_req_low", req_valid, 1'b0);
        check("wait_rdy_low", rdy, 1'b0);
        rst = 1'b0;
        ex_mem.valid = 1'b0;
        #1;
        check("rst_wb_valid", mem_wb.valid, 1'b0);
        check("rst_req_low", req_valid, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        rsp_delay = 0;
        @(posedge clk);
        #1;
        stray_rsp = 1'b1;
        issue(1'b1, 32'h00002283, 32'h00000028, 32'h0, c);
        check("post_rst_latency", c, 2);

        // randomized traffic
        en_pct = 80; ready_wait = -1; rsp_delay = -1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            inst = $urandom;
            addr = $urandom;
            rs2  = $urandom;
            if (kind == 0) begin
                issue(1'b0, inst, addr, rs2, c);
            end else if (kind <= 3) begin
                inst[6:0] = 7'b0110011;
                issue(1'b1, inst, addr, rs2, c);
            end else if (kind <= 6) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                inst[6:0] = 7'b0000011;
                inst[14:12] = 3'(f3);
                issue(1'b1, inst, addr, rs2, c);
            end else begin
                inst[6:0] = 7'b0100011;
                inst[14:12] = 3'($urandom_range(0, 2));
                issue(1'b1, inst, addr, rs2, c);
            end
        end
        en_pct = 100;
        issue(1'b0, 32'h0, 32'h0, 32'h0, c);
        issue(1'b0, 32'h0, 32'h0, 32'h0, c);
        @(negedge clk);
        #4;
        check("wb_queue_drained", wb_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
